i2s_deserializer: RTL and testbench
===================================

I2S_DESERIALIZER -- requirements
Module: i2s_deserializer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on each of bck, wclk and sdata (legal range 2..3).
REQ-002 SHALL have parameter WIDTH, default 16, meaning bits per channel slot.
REQ-003 SHALL have port mclk  input  1  single system clock (16.384 MHz); all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bck  input  1  serial bit clock, asynchronous to mclk, treated as data.
REQ-006 SHALL have port wclk  input  1  word select, asynchronous: 0 = left slot, 1 = right slot.
REQ-007 SHALL have port sdata  input  1  serial data, asynchronous, MSB first.
REQ-008 SHALL have port data  output  2*WIDTH  last complete frame {left, right}.
REQ-009 SHALL have port valid  output  1  one-mclk pulse when data is updated.
REQ-010 SHALL have port err  output  1  one-mclk pulse on a framing error.
REQ-011 SHALL have port locked  output  1  high while receiving a correctly framed stream.

Function
REQ-012 SHALL pass bck, wclk and sdata through identical SYNC_STAGES-deep synchronizers, so the three signals keep their relative alignment.
REQ-013 SHALL detect a bck rising edge as synced bck = 1 while its previous registered value = 0, giving one "tick" per bck period.
REQ-014 SHALL sample synced wclk and sdata only on tick cycles; the transmitter changes them on bck falling edges.
REQ-015 SHALL support bck high and low phases of at least 4 mclk each; the nominal ratio is mclk/16.
REQ-016 SHALL use the slot format: slot starts on the bit where wclk changes, WIDTH bits per slot, MSB first, no one-bit delay.
REQ-017 SHALL implement the states HUNT, LEFT and RIGHT, plus a slot bit counter cnt (0..WIDTH).
REQ-018 In HUNT, SHALL move to LEFT on a tick with wclk=0 whose previous tick had wclk=1, and shift that bit in as left MSB with cnt=1.
REQ-019 In LEFT, SHALL shift on each tick with wclk=0 while cnt<WIDTH.
REQ-020 When cnt==WIDTH, SHALL require the next tick to have wclk=1, then move to RIGHT, shift that bit as right MSB and set cnt=1.
REQ-021 In RIGHT, SHALL handle ticks symmetrically, with wclk=1 while cnt<WIDTH.
REQ-022 On the tick completing the WIDTH-th right bit, SHALL load data={left,right} and pulse valid in the following mclk cycle.
REQ-023 After that completing tick, SHALL require the next tick to have wclk=0, then move to LEFT with cnt=1.
REQ-024 On a framing error (wclk changes with cnt<WIDTH, or fails to change when cnt==WIDTH), SHALL pulse err one cycle, go to HUNT, discard the partial frame, leave data unchanged and clear locked.
REQ-025 If the error tick itself is a 1->0 wclk transition, SHALL not resynchronize on that tick; re-entry to LEFT requires a later qualifying tick.
REQ-026 SHALL set locked on the first valid pulse and clear it on error or reset.
REQ-027 SHALL hold all outputs stable between events; valid and err are never high in the same cycle.

Reset
REQ-028 SHALL, on rst_n low, immediately and asynchronously clear: state=HUNT, cnt=0, shift registers=0, data=0, valid=0, err=0, locked=0, and all synchronizer and edge flops to 0.
REQ-029 SHALL, on reset asserted mid-frame, lose the partial frame; after release it resumes only via the HUNT rule, with no spurious valid or err.

Verification
REQ-030 SHALL cover nominal stream: bck=mclk/16, frames L=16'h8001, R=16'h7FFE -> data=32'h80017FFE, one valid per frame, every 512 mclk, err never asserted.
REQ-031 SHALL cover lock-up: reset released mid-right-slot -> no valid until one full left+right slot has been received after the first wclk falling edge; locked rises together with the first valid.
REQ-032 SHALL cover a short slot: wclk toggles after 15 left bits -> single err pulse, locked=0, data retains its previous value, relock on the next correct frame.
REQ-033 SHALL cover a long slot: wclk held 0 for 17 bits -> err on the 17th tick, HUNT.
REQ-034 SHALL cover minimum timing: bck at 4 mclk high / 4 mclk low with random data -> all frames match the sent values bit-exact.
REQ-035 SHALL cover async reset pulse mid-frame -> all outputs 0 within the same mclk cycle, correct reception after relock.

Source files
------------

// File: rtl/i2s_deserializer.sv
// I2S receiver: synchronizes bck/wclk/sdata into the mclk domain, tracks the
// left/right slot framing, and emits one {left, right} word per complete frame.
module i2s_deserializer #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 16
) (
    input  logic               mclk,
    input  logic               rst_n,
    input  logic               bck,
    input  logic               wclk,
    input  logic               sdata,
    output logic [2*WIDTH-1:0] data,
    output logic               valid,
    output logic               err,
    output logic               locked
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] bck_sync_q, wclk_sync_q, sdata_sync_q;
    logic                   bck_prev_q, wclk_prev_q;
    logic                   bck_s, wclk_s, sdata_s, tick;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       left_q, left_d, right_q, right_d;
    logic [2*WIDTH-1:0]     data_q, data_d;
    logic                   valid_q, valid_d, err_q, err_d, locked_q, locked_d;
    logic                   slot_full, frame_err;

    // All three inputs share one chain depth so bit/word/data stay aligned.
    assign bck_s   = bck_sync_q[SYNC_STAGES-1];
    assign wclk_s  = wclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign tick    = bck_s & ~bck_prev_q;

    // NOTE: sequential state uses non-blocking assignments and an async reset
    // that clears every flop, including the synchronizers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync_q   <= '0;
            wclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            bck_prev_q   <= 1'b0;
            wclk_prev_q  <= 1'b0;
            state_q      <= HUNT;
            cnt_q        <= '0;
            left_q       <= '0;
            right_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            bck_sync_q   <= {bck_sync_q[SYNC_STAGES-2:0], bck};
            wclk_sync_q  <= {wclk_sync_q[SYNC_STAGES-2:0], wclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
            bck_prev_q   <= bck_s;
            if (tick) wclk_prev_q <= wclk_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            left_q       <= left_d;
            right_q      <= right_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
        end
    end

    assign slot_full = (cnt_q == CW'(WIDTH));

    // NOTE: every next-state signal gets a default first, so no latches form.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        right_d   = right_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        locked_d  = locked_q;
        frame_err = 1'b0;

        if (tick) begin
            case (state_q)
                HUNT: begin
                    if (!wclk_s && wclk_prev_q) begin
                        state_d = LEFT;
                        left_d  = {left_q[WIDTH-2:0], sdata_s};
                        cnt_d   = CW'(1);
                    end
                end
                LEFT: begin
                    if (slot_full) begin
                        if (wclk_s) begin
                            state_d = RIGHT;
                            right_d = {right_q[WIDTH-2:0], sdata_s};
                            cnt_d   = CW'(1);
                        end else begin
                            frame_err = 1'b1;
                        end
                    end else if (!wclk_s) begin
                        left_d = {left_q[WIDTH-2:0], sdata_s};
                        cnt_d  = cnt_q + CW'(1);
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                RIGHT: begin
                    if (slot_full) begin
                        if (!wclk_s) begin
                            state_d = LEFT;
                            left_d  = {left_q[WIDTH-2:0], sdata_s};
                            cnt_d   = CW'(1);
                        end else begin
                            frame_err = 1'b1;
                        end
                    end else if (wclk_s) begin
                        right_d = {right_q[WIDTH-2:0], sdata_s};
                        cnt_d   = cnt_q + CW'(1);
                        // Last right bit: publish the frame on the next cycle.
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            data_d   = {left_q, right_d};
                            valid_d  = 1'b1;
                            locked_d = 1'b1;
                        end
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (frame_err) begin
            state_d  = HUNT;
            cnt_d    = '0;
            left_d   = '0;
            right_d  = '0;
            err_d    = 1'b1;
            locked_d = 1'b0;
        end
    end

    assign data   = data_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_i2s_deserializer.sv
// Directed bench for i2s_deserializer: drives an I2S stream, pushes expected
// frames to a scoreboard and compares them against each valid pulse.
module tb_i2s_deserializer;

    localparam int W = 16;

    logic           mclk = 1'b0;
    logic           rst_n;
    logic           bck, wclk, sdata;
    logic [2*W-1:0] data;
    logic           valid, err, locked;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_valid   = 0;
    int n_err_obs = 0;
    int exp_err   = 0;
    int cyc       = 0;
    int last_v    = -1;
    bit period_chk = 1'b0;
    int lo_cyc = 8;
    int hi_cyc = 8;

    logic [31:0] sb[$];
    logic [31:0] last_good;

    i2s_deserializer #(.SYNC_STAGES(2), .WIDTH(W)) dut (
        .mclk   (mclk),
        .rst_n  (rst_n),
        .bck    (bck),
        .wclk   (wclk),
        .sdata  (sdata),
        .data   (data),
        .valid  (valid),
        .err    (err),
        .locked (locked)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: each valid pulse must match the oldest pending frame.
    always @(negedge mclk) begin
        if (rst_n === 1'b1) begin
            if (err === 1'b1) n_err_obs++;
            if (valid === 1'b1 && err === 1'b1) check("valid_err_same_cycle", 32'd1, 32'd0);
            if (valid === 1'b1) begin
                n_valid++;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    check("frame_data", data, sb.pop_front());
                    check("locked_with_valid", {31'd0, locked}, 32'd1);
                    if (period_chk && last_v >= 0) check("valid_period", cyc - last_v, 32'd512);
                    last_v = cyc;
                end
            end
        end
    end

    // One bck period: data changes with bck falling, then bck rises.
    task automatic send_bit(input logic w, input logic d, input bit push, input logic [31:0] frame);
        @(negedge mclk);
        bck = 1'b0; wclk = w; sdata = d;
        repeat (lo_cyc) @(negedge mclk);
        bck = 1'b1;
        if (push) sb.push_back(frame);
        repeat (hi_cyc - 1) @(negedge mclk);
    endtask

    task automatic send_slot(input logic w, input logic [15:0] v, input int n,
                             input bit push, input logic [31:0] frame);
        for (int i = 0; i < n; i++) begin
            logic d;
            if (i < 16) d = v[4'(15 - i)];
            else        d = 1'b0;
            send_bit(w, d, push && (i == n - 1), frame);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit push);
        send_slot(1'b0, l, 16, 1'b0, 32'd0);
        send_slot(1'b1, r, 16, push, {l, r});
        if (push) last_good = {l, r};
    endtask

    task automatic settle_and_check_err(input string tag);
        repeat (4) @(negedge mclk);
        check(tag, n_err_obs, exp_err);
    endtask

    initial begin
        rst_n = 1'b0; bck = 1'b0; wclk = 1'b0; sdata = 1'b0;
        last_good = '0;
        repeat (3) @(negedge mclk);
        check("reset_data",   data,             32'd0);
        check("reset_valid",  {31'd0, valid},   32'd0);
        check("reset_err",    {31'd0, err},     32'd0);
        check("reset_locked", {31'd0, locked},  32'd0);

        // Lock-up: reset released in the middle of a right slot.
        send_slot(1'b1, 16'hBEEF, 6, 1'b0, 32'd0);
        @(negedge mclk); rst_n = 1'b1;
        send_slot(1'b1, 16'hEF00, 10, 1'b0, 32'd0);
        send_slot(1'b0, 16'h1234, 16, 1'b0, 32'd0);
        repeat (4) @(negedge mclk);
        check("lockup_no_valid", n_valid,            32'd0);
        check("lockup_unlocked", {31'd0, locked},    32'd0);
        send_slot(1'b1, 16'h5678, 16, 1'b1, 32'h1234_5678);
        last_good = 32'h1234_5678;

        // Nominal stream, one frame every 512 mclk.
        period_chk = 1'b1; last_v = -1;
        for (int f = 0; f < 4; f++) send_frame(16'h8001, 16'h7FFE, 1'b1);
        repeat (4) @(negedge mclk);
        period_chk = 1'b0;
        check("nominal_data",    data,            32'h8001_7FFE);
        check("nominal_locked",  {31'd0, locked}, 32'd1);
        settle_and_check_err("nominal_no_err");

        // Short left slot: wclk rises after 15 bits.
        send_slot(1'b0, 16'hAAAA, 15, 1'b0, 32'd0);
        send_slot(1'b1, 16'h5555, 16, 1'b0, 32'd0);
        exp_err++;
        settle_and_check_err("short_slot_err");
        check("short_slot_unlocked", {31'd0, locked}, 32'd0);
        check("short_slot_data_kept", data, last_good);
        send_frame(16'h1357, 16'h2468, 1'b1);
        repeat (4) @(negedge mclk);
        check("short_slot_relock", {31'd0, locked}, 32'd1);

        // Long left slot: wclk stays low for 17 bits.
        send_slot(1'b0, 16'hFFFF, 17, 1'b0, 32'd0);
        exp_err++;
        settle_and_check_err("long_slot_err");
        check("long_slot_unlocked", {31'd0, locked}, 32'd0);
        check("long_slot_data_kept", data, last_good);
        send_slot(1'b1, 16'h0F0F, 16, 1'b0, 32'd0);
        send_frame(16'hCAFE, 16'hF00D, 1'b1);

        // Short right slot: the error tick is itself a 1->0 wclk edge.
        send_slot(1'b0, 16'h1111, 16, 1'b0, 32'd0);
        send_slot(1'b1, 16'h2222, 15, 1'b0, 32'd0);
        send_slot(1'b0, 16'h3333, 16, 1'b0, 32'd0);
        exp_err++;
        settle_and_check_err("fall_edge_err");
        send_slot(1'b1, 16'h4444, 16, 1'b0, 32'd0);
        check("fall_edge_no_resync", {31'd0, locked}, 32'd0);
        send_frame(16'h0001, 16'h8000, 1'b1);

        // Minimum bck timing with random payloads.
        lo_cyc = 4; hi_cyc = 4;
        for (int f = 0; f < 6; f++) send_frame(16'($urandom), 16'($urandom), 1'b1);
        repeat (4) @(negedge mclk);
        check("min_timing_data", data, last_good);
        lo_cyc = 8; hi_cyc = 8;

        // Asynchronous reset pulse in the middle of a left slot.
        check("pre_reset_locked", {31'd0, locked}, 32'd1);
        send_slot(1'b0, 16'hC0DE, 8, 1'b0, 32'd0);
        @(negedge mclk); #2 rst_n = 1'b0;
        #1;
        check("async_rst_data",   data,            32'd0);
        check("async_rst_valid",  {31'd0, valid},  32'd0);
        check("async_rst_err",    {31'd0, err},    32'd0);
        check("async_rst_locked", {31'd0, locked}, 32'd0);
        repeat (2) @(negedge mclk); rst_n = 1'b1;
        send_slot(1'b0, 16'hDE00, 8, 1'b0, 32'd0);
        send_slot(1'b1, 16'h9999, 16, 1'b0, 32'd0);
        send_frame(16'hA5A5, 16'h5A5A, 1'b1);
        send_frame(16'hFFFF, 16'h0000, 1'b1);

        repeat (20) @(negedge mclk);
        check("final_data",      data,                32'hFFFF_0000);
        check("scoreboard_empty", sb.size(),          32'd0);
        check("total_valid",     n_valid,             32'd16);
        check("total_err",       n_err_obs,           exp_err);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
